result_copy_arbiter: RTL and testbench

Round-robin scheduler that shares one result-copy engine among N_REQ wordcount result memories. Each requester posts a copy job: source word offset, word count and host destination address. The arbiter grants one job at a time, drives the engine's kick/parameter inputs and steers the engine's memory read port to the granted requester's result RAM. It signals per-requester completion and keeps job statistics.

---
 rtl/result_copy_arbiter.sv | 119 +++++++++++
 tb/tb_result_copy_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_copy_arbiter.sv
// rtl/result_copy_arbiter.sv - round-robin arbiter sharing one result-copy engine among N_REQ result memories
module result_copy_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  req_offset,
    input  logic [N_REQ*32-1:0]  req_words,
    input  logic [N_REQ*64-1:0]  req_dst,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          mem_addr,
    input  logic [N_REQ*64-1:0]  mem_q,
    output logic                 eng_kick,
    input  logic                 eng_busy,
    output logic [31:0]          eng_offset,
    output logic [31:0]          eng_words,
    output logic [63:0]          eng_memory_addr,
    input  logic [31:0]          eng_addr,
    output logic [63:0]          eng_q,
    output logic                 arb_busy,
    output logic [2:0]           grant_idx,
    output logic [31:0]          job_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    localparam logic [N_REQ-1:0] DONE_ONE = N_REQ'(1);

    state_t             state;
    state_t             next_state;
    logic [2:0]         last_grant;
    logic [2:0]         win_idx;
    logic               found;
    logic [N_REQ-1:0]   eff_req;
    logic [31:0]        win_offset;
    logic [31:0]        win_words;
    logic [63:0]        win_dst;

    // A requester still holds req during its own done cycle; that stale level must not re-grant it.
    assign eff_req = req & ~done;

    always_comb begin
        int cand;
        cand    = 0;
        found   = 1'b0;
        win_idx = 3'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && eff_req[cand]) begin
                found   = 1'b1;
                win_idx = 3'(cand);
            end
        end
    end

    assign win_offset = req_offset[32*int'(win_idx) +: 32];
    assign win_words  = req_words[32*int'(win_idx) +: 32];
    assign win_dst    = req_dst[64*int'(win_idx) +: 64];

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (found && !eng_busy) begin
                    next_state = (win_words == 32'd0) ? ST_DONE : ST_KICK;
                end
            end
            ST_KICK:       next_state = ST_WAIT_START;
            ST_WAIT_START: if (eng_busy)  next_state = ST_WAIT_DONE;
            ST_WAIT_DONE:  if (!eng_busy) next_state = ST_DONE;
            ST_DONE:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            eng_kick        <= 1'b0;
            done            <= '0;
            eng_offset      <= 32'd0;
            eng_words       <= 32'd0;
            eng_memory_addr <= 64'd0;
            grant_idx       <= 3'd0;
            last_grant      <= 3'(N_REQ - 1);
            job_count       <= 32'd0;
        end else begin
            state    <= next_state;
            eng_kick <= (next_state == ST_KICK);
            done     <= '0;
            if (state == ST_IDLE && next_state != ST_IDLE) begin
                grant_idx       <= win_idx;
                eng_offset      <= win_offset;
                eng_words       <= win_words;
                eng_memory_addr <= win_dst;
            end
            if (state == ST_DONE) begin
                done       <= DONE_ONE << grant_idx;
                last_grant <= grant_idx;
                job_count  <= job_count + 32'd1;
            end
        end
    end

    assign arb_busy = (state != ST_IDLE);
    assign mem_addr = eng_addr;
    assign eng_q    = mem_q[64*int'(grant_idx) +: 64];

endmodule

// File: tb/tb_result_copy_arbiter.sv
// tb/tb_result_copy_arbiter.sv - self-checking bench for result_copy_arbiter
module tb_result_copy_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*32-1:0]   req_offset;
    logic [N*32-1:0]   req_words;
    logic [N*64-1:0]   req_dst;
    logic [N-1:0]      done;
    logic [31:0]       mem_addr;
    logic [N*64-1:0]   mem_q;
    logic              eng_kick;
    logic              eng_busy;
    logic [31:0]       eng_offset;
    logic [31:0]       eng_words;
    logic [63:0]       eng_memory_addr;
    logic [31:0]       eng_addr;
    logic [63:0]       eng_q;
    logic              arb_busy;
    logic [2:0]        grant_idx;
    logic [31:0]       job_count;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;

    result_copy_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_offset(req_offset),
        .req_words(req_words), .req_dst(req_dst), .done(done), .mem_addr(mem_addr),
        .mem_q(mem_q), .eng_kick(eng_kick), .eng_busy(eng_busy), .eng_offset(eng_offset),
        .eng_words(eng_words), .eng_memory_addr(eng_memory_addr), .eng_addr(eng_addr),
        .eng_q(eng_q), .arb_busy(arb_busy), .grant_idx(grant_idx), .job_count(job_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i, input logic [31:0] a);
        logic [7:0] tag;
        tag = 8'hA0 + 8'(i);
        return {tag, 24'h5A5A5A, a};
    endfunction

    always_comb begin
        mem_q = '0;
        for (int i = 0; i < N; i++) mem_q[i*64 +: 64] = pat(i, eng_addr);
    end

    typedef struct {
        int          idx;
        logic [31:0] off;
        logic [31:0] words;
        logic [63:0] dst;
        int          busy_len;
        logic        exp_kick;
        logic [3:0]  exp_done;
    } job_t;

    job_t jobs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic wait_kick();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (eng_kick) return;
        end
        timeout("wait_kick");
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done != 0) return;
        end
        timeout("wait_done");
    endtask

    task automatic check_reset_state();
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_kick", eng_kick, 0);
        chk("rst_done", done, 0);
        chk("rst_offset", eng_offset, 0);
        chk("rst_words", eng_words, 0);
        chk("rst_dst", eng_memory_addr, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_job_count", job_count, 0);
    endtask

    task automatic run_job(input job_t j);
        req_offset[j.idx*32 +: 32] = j.off;
        req_words[j.idx*32 +: 32]  = j.words;
        req_dst[j.idx*64 +: 64]    = j.dst;
        req[j.idx] = 1'b1;
        eng_busy   = 1'b0;
        tick();
        chk("kick", eng_kick, j.exp_kick);
        chk("grant", grant_idx, j.idx);
        chk("busy_in_job", arb_busy, 1);
        chk("eng_offset", eng_offset, j.off);
        chk("eng_words", eng_words, j.words);
        chk("eng_dst", eng_memory_addr, j.dst);
        // changing the requester's fields after grant must not disturb the job
        req_offset[j.idx*32 +: 32] = 32'hDEAD_BEEF;
        req_dst[j.idx*64 +: 64]    = 64'h0;
        if (j.exp_kick) begin
            tick();
            chk("kick_one_cycle", eng_kick, 0);
            eng_busy = 1'b1;
            for (int n = 0; n < j.busy_len; n++) begin
                tick();
                chk("done_early", done, 0);
            end
            eng_busy = 1'b0;
            tick();
            chk("done_early", done, 0);
            chk("offset_stable", eng_offset, j.off);
            chk("dst_stable", eng_memory_addr, j.dst);
        end
        tick();
        exp_jobs++;
        chk("done_pulse", done, j.exp_done);
        chk("job_count", job_count, exp_jobs);
        req[j.idx] = 1'b0;
        tick();
        chk("done_cleared", done, 0);
        chk("idle_after", arb_busy, 0);
    endtask

    initial begin
        jobs[0] = '{1, 32'h10, 32'd20, 64'h1000, 3, 1'b1, 4'b0010};
        jobs[1] = '{3, 32'h0, 32'd0, 64'hABC0, 0, 1'b0, 4'b1000};
        jobs[2] = '{0, 32'hFFFF_FFF0, 32'd1, 64'hFFFF_0000_1234_5678, 1, 1'b1, 4'b0001};
        jobs[3] = '{2, 32'h55, 32'h100, 64'h8000, 5, 1'b1, 4'b0100};

        reset = 1'b1; req = '0; req_offset = '0; req_words = '0; req_dst = '0;
        eng_busy = 1'b1; eng_addr = 32'd0;

        // reset hold-off: engine busy after reset, requester 0 already waiting
        req[0] = 1'b1;
        req_words[31:0] = 32'd5;
        req_offset[31:0] = 32'h40;
        req_dst[63:0] = 64'h2000;
        tick(); tick();
        reset = 1'b0;
        check_reset_state();
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("holdoff_no_kick", eng_kick, 0);
        end
        eng_busy = 1'b0;
        tick();
        chk("holdoff_kick", eng_kick, 1);
        chk("holdoff_grant", grant_idx, 0);
        tick(); eng_busy = 1'b1;
        tick(); eng_busy = 1'b0;
        tick(); tick();
        exp_jobs++;
        chk("holdoff_done", done, 4'b0001);
        chk("holdoff_count", job_count, exp_jobs);
        req = '0;
        tick();

        for (int i = 0; i < 4; i++) run_job(jobs[i]);

        // eng_q follows requester 2's RAM for every engine address
        req[2] = 1'b1;
        req_words[2*32 +: 32] = 32'd8;
        wait_kick();
        tick(); eng_busy = 1'b1;
        tick();
        for (int a = 0; a < 6; a++) begin
            logic [31:0] addr;
            addr = 32'h100 * 32'(a) + 32'(a);
            eng_addr = addr;
            #1;
            chk("mux_eng_q", eng_q, pat(2, addr));
            chk("mem_addr", mem_addr, addr);
            tick();
        end
        eng_busy = 1'b0;
        wait_done();
        exp_jobs++;
        chk("mux_done", done, 4'b0100);
        req = '0;
        tick();

        // fairness from reset: all four held continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_jobs = 0;
        for (int i = 0; i < N; i++) req_words[i*32 +: 32] = 32'd4;
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            wait_kick();
            chk("rr_grant", grant_idx, j % 4);
            tick(); eng_busy = 1'b1;
            tick(); eng_busy = 1'b0;
            wait_done();
            exp_jobs++;
            chk("rr_done", done, 4'b0001 << (j % 4));
        end
        chk("rr_job_count", job_count, 8);
        req = '0;
        tick();

        // reset while the engine is mid-copy
        req[0] = 1'b1;
        req_words[31:0] = 32'd7;
        wait_kick();
        tick(); eng_busy = 1'b1;
        tick();
        chk("midjob_busy", arb_busy, 1);
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0; req = '0; eng_busy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("midjob_no_done", done, 0);
        end
        exp_jobs = 0;
        run_job(jobs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end
endmodule
